// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-lane alignment, request/grant/response sequencing, load extension.
// Latency: accept -> REQ -> WAIT -> DONE; with immediate grant and next-cycle response the result appears 3 cycles after acceptance.
// Backpressure: lsu_stall is held through REQ and WAIT; fields stay stable while mem_gnt is low; WAIT gives up after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   req_valid, ctrl_mem_write, ctrl_mem2reg, ctrl_word_size, addr, store_data
//                                  pipeline request (funct3 size encoding)
//   lsu_stall                      freeze the pipeline while an access is in flight
//   load_data, load_valid          extended load result and its one-cycle valid
//   misaligned, bus_err            rejected access (combinational) / response timeout
//   mem_req, mem_we, mem_be, mem_addr, mem_wdata, mem_gnt, mem_rvalid, mem_rdata
//                                  data-memory port
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        ctrl_mem_write,
  input  logic        ctrl_mem2reg,
  input  logic [2:0]  ctrl_word_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   ld_q, ld_d;
  logic [31:0]   addr_q;
  logic [2:0]    size_q;
  logic          we_q;
  logic          m2r_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic          bad_op, bad_align, accept;
  logic [31:0]   wdata_al;
  logic [3:0]    be_al;
  logic [31:0]   lane, ext;

  // Request legality: unsupported funct3 for the direction, or a halfword/word
  // not on its natural boundary.
  always_comb begin
    bad_op = 1'b0;
    if (ctrl_mem_write)
      bad_op = !(ctrl_word_size inside {3'b000, 3'b001, 3'b010});
    else
      bad_op = !(ctrl_word_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    bad_align = ((ctrl_word_size[1:0] == 2'b01) && addr[0]) ||
                ((ctrl_word_size == 3'b010) && (addr[1:0] != 2'b00));
  end

  assign misaligned = (state_q == IDLE) && req_valid && (bad_op || bad_align);
  assign accept     = (state_q == IDLE) && req_valid && !(bad_op || bad_align);

  // Store data is replicated across lanes so the enabled lanes always carry
  // the right bytes; loads read the whole word and pick the lane afterwards.
  always_comb begin
    wdata_al = store_data;
    be_al    = 4'b1111;
    case (ctrl_word_size[1:0])
      2'b00: begin
        wdata_al = {4{store_data[7:0]}};
        be_al    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_al = {2{store_data[15:0]}};
        be_al    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_al = store_data;
        be_al    = 4'b1111;
      end
    endcase
    if (!ctrl_mem_write)
      be_al = 4'b1111;
  end

  // Load lane select and extension from the latched offset and size.
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = REQ;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      REQ: if (mem_gnt) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A response arriving on the last allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          state_d = DONE;
          if (!we_q)
            ld_d = ext;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          ld_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      m2r_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      if (accept) begin
        addr_q  <= addr;
        size_q  <= ctrl_word_size;
        we_q    <= ctrl_mem_write;
        m2r_q   <= ctrl_mem2reg;
        wdata_q <= wdata_al;
        be_q    <= be_al;
      end
    end
  end

  assign mem_req    = (state_q == REQ);
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign lsu_stall  = accept || (state_q == REQ) || (state_q == WAIT);
  assign load_valid = (state_q == DONE) && !we_q && m2r_q && !err_q;
  assign bus_err    = (state_q == DONE) && err_q;
  assign load_data  = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, ctrl_mem_write, ctrl_mem2reg;
  logic [2:0]  ctrl_word_size;
  logic [31:0] addr, store_data;
  logic        lsu_stall, load_valid, misaligned, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Observations recorded by run_op; each test compares them itself.
  logic        o_mis, o_stall0, o_req0;
  logic        o_req, o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata;
  logic        o_stable;
  int          o_nstall;
  logic        o_lv, o_berr, o_stall_done;
  logic [31:0] o_ld;
  logic        o_lv_after, o_stall_after, o_berr_after;
  logic [31:0] exp_ld;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .ctrl_mem_write(ctrl_mem_write), .ctrl_mem2reg(ctrl_mem2reg),
    .ctrl_word_size(ctrl_word_size), .addr(addr), .store_data(store_data),
    .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) return 1'b0;
    if (we && sz > 3'b010) return 1'b0;
    return (int'(a[1:0]) % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] be;
    int off, n;
    if (!we) return 4'b1111;
    be = 4'b0000;
    off = int'(a[1:0]);
    n = nbytes(sz);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] sd);
    logic [31:0] w;
    int n;
    n = nbytes(sz);
    w = '0;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int off, n;
    off = int'(a[1:0]);
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v + (longint'(rd[8*(off+i) +: 8]) << (8*i));
    if (sz[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8*n-1)))
      v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // ---------------- transaction driver (records, does not compare) ----------------
  task automatic run_op(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] sd, input int g, input int rd,
                        input logic [31:0] rdata);
    int wc;
    @(negedge clk);
    req_valid = 1'b1; ctrl_mem_write = we; ctrl_mem2reg = !we;
    ctrl_word_size = sz; addr = a; store_data = sd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    o_mis = misaligned; o_stall0 = lsu_stall; o_req0 = mem_req;
    o_nstall = int'(lsu_stall);
    if (!ref_legal(we, sz, a)) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      o_stall_after = lsu_stall; o_lv_after = load_valid; o_berr_after = bus_err;
      return;
    end
    @(negedge clk);
    o_req = mem_req; o_we = mem_we; o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata;
    o_stable = 1'b1;
    for (int i = 0; i <= g; i++) begin
      if (mem_req !== o_req || mem_we !== o_we || mem_be !== o_be ||
          mem_addr !== o_addr || mem_wdata !== o_wdata || lsu_stall !== 1'b1)
        o_stable = 1'b0;
      o_nstall += int'(lsu_stall);
      if (i == g) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    wc = (rd < TO) ? rd + 1 : TO;
    for (int i = 0; i < wc; i++) begin
      o_nstall += int'(lsu_stall);
      if (rd < TO && i == rd) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    o_lv = load_valid; o_ld = load_data; o_berr = bus_err; o_stall_done = lsu_stall;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    o_stall_after = lsu_stall; o_lv_after = load_valid; o_berr_after = bus_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b0;
    ctrl_word_size = 3'b000; addr = '0; store_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #3;
    chk_cnt++;
    if ({lsu_stall, load_valid, misaligned, bus_err, mem_req, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000",
               {lsu_stall, load_valid, misaligned, bus_err, mem_req, mem_we});
    else pass_cnt++;
    chk_cnt++;
    if ({load_data, mem_addr, mem_wdata, mem_be} !== 100'd0)
      $display("FAIL reset_data ld=%h addr=%h wd=%h be=%b exp all zero",
               load_data, mem_addr, mem_wdata, mem_be);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (load_valid !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL reset_stray_rvalid lv=%b stall=%b exp 0/0", load_valid, lsu_stall);
    else pass_cnt++;
    mem_rvalid = 1'b0;
    exp_ld = '0;
  endtask

  task automatic test_basic_load;
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk_cnt++;
    if (o_mis !== 1'b0 || o_stall0 !== 1'b1)
      $display("FAIL lw_accept mis=%b stall=%b exp 0/1", o_mis, o_stall0);
    else pass_cnt++;
    chk_cnt++;
    if (o_req !== 1'b1 || o_we !== 1'b0 || o_be !== 4'b1111 || o_addr !== 32'h100)
      $display("FAIL lw_bus req=%b we=%b be=%b addr=%h exp 1/0/1111/00000100",
               o_req, o_we, o_be, o_addr);
    else pass_cnt++;
    chk_cnt++;
    if (o_nstall !== 3)
      $display("FAIL lw_stall_cycles got=%0d exp=3", o_nstall);
    else pass_cnt++;
    chk_cnt++;
    if (o_lv !== 1'b1 || o_ld !== 32'hDEAD_BEEF || o_stall_done !== 1'b0)
      $display("FAIL lw_done lv=%b ld=%h stall=%b exp 1/deadbeef/0", o_lv, o_ld, o_stall_done);
    else pass_cnt++;
    chk_cnt++;
    if (o_lv_after !== 1'b0 || o_stall_after !== 1'b0)
      $display("FAIL lw_pulse lv=%b stall=%b exp 0/0", o_lv_after, o_stall_after);
    else pass_cnt++;
    exp_ld = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte_loads;
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
    chk_cnt++;
    if (o_ld !== 32'hFFFF_FF80) $display("FAIL lb got=%h exp=ffffff80", o_ld);
    else pass_cnt++;
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
    chk_cnt++;
    if (o_ld !== 32'h0000_0080) $display("FAIL lbu got=%h exp=00000080", o_ld);
    else pass_cnt++;
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80FF_FFFF);
    chk_cnt++;
    if (o_ld !== 32'h0000_80FF) $display("FAIL lhu got=%h exp=000080ff", o_ld);
    else pass_cnt++;
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80FF_FFFF);
    chk_cnt++;
    if (o_ld !== 32'hFFFF_80FF) $display("FAIL lh got=%h exp=ffff80ff", o_ld);
    else pass_cnt++;
    exp_ld = 32'hFFFF_80FF;
  endtask

  task automatic test_stores;
    run_op(1'b1, 3'b000, 32'h201, 32'h1234_5678, 0, 0, 32'h0);
    chk_cnt++;
    if (o_we !== 1'b1 || o_be !== 4'b0010 || o_wdata !== 32'h7878_7878 || o_addr !== 32'h200)
      $display("FAIL sb we=%b be=%b wd=%h addr=%h exp 1/0010/78787878/00000200",
               o_we, o_be, o_wdata, o_addr);
    else pass_cnt++;
    chk_cnt++;
    if (o_lv !== 1'b0 || o_berr !== 1'b0 || o_ld !== exp_ld)
      $display("FAIL sb_done lv=%b berr=%b ld=%h exp 0/0/%h", o_lv, o_berr, o_ld, exp_ld);
    else pass_cnt++;
    run_op(1'b1, 3'b001, 32'h202, 32'h1234_5678, 0, 0, 32'h0);
    chk_cnt++;
    if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'h5678_5678)
      $display("FAIL sh we=%b be=%b wd=%h exp 1/1100/56785678", o_we, o_be, o_wdata);
    else pass_cnt++;
    chk_cnt++;
    if (o_lv !== 1'b0) $display("FAIL sh_lv got=%b exp=0", o_lv);
    else pass_cnt++;
  endtask

  task automatic test_misaligned;
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
    chk_cnt++;
    if (o_mis !== 1'b1 || o_req0 !== 1'b0 || o_stall0 !== 1'b0)
      $display("FAIL mis_lw mis=%b req=%b stall=%b exp 1/0/0", o_mis, o_req0, o_stall0);
    else pass_cnt++;
    run_op(1'b1, 3'b001, 32'h101, 32'hAAAA_5555, 0, 0, 32'h0);
    chk_cnt++;
    if (o_mis !== 1'b1 || o_req0 !== 1'b0 || o_stall0 !== 1'b0)
      $display("FAIL mis_sh mis=%b req=%b stall=%b exp 1/0/0", o_mis, o_req0, o_stall0);
    else pass_cnt++;
    chk_cnt++;
    if (o_stall_after !== 1'b0 || o_lv_after !== 1'b0)
      $display("FAIL mis_after stall=%b lv=%b exp 0/0", o_stall_after, o_lv_after);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    run_op(1'b1, 3'b010, 32'h3C4, 32'hCAFE_F00D, 5, 0, 32'h0);
    chk_cnt++;
    if (o_stable !== 1'b1 || o_req !== 1'b1 || o_wdata !== 32'hCAFE_F00D)
      $display("FAIL bp_stable stable=%b req=%b wd=%h exp 1/1/cafef00d", o_stable, o_req, o_wdata);
    else pass_cnt++;
    chk_cnt++;
    if (o_nstall !== 8) $display("FAIL bp_stall_cycles got=%0d exp=8", o_nstall);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 0, TO, 32'h0);
    chk_cnt++;
    if (o_berr !== 1'b1 || o_ld !== 32'h0 || o_lv !== 1'b0)
      $display("FAIL timeout berr=%b ld=%h lv=%b exp 1/00000000/0", o_berr, o_ld, o_lv);
    else pass_cnt++;
    chk_cnt++;
    if (o_berr_after !== 1'b0 || o_stall_after !== 1'b0 || o_nstall !== 2 + TO)
      $display("FAIL timeout_after berr=%b stall=%b ncyc=%0d exp 0/0/%0d",
               o_berr_after, o_stall_after, o_nstall, 2 + TO);
    else pass_cnt++;
    exp_ld = '0;
    // Response on the final allowed WAIT cycle is still accepted.
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 0, TO - 1, 32'h1357_9BDF);
    chk_cnt++;
    if (o_berr !== 1'b0 || o_lv !== 1'b1 || o_ld !== 32'h1357_9BDF)
      $display("FAIL late_rvalid berr=%b lv=%b ld=%h exp 0/1/13579bdf", o_berr, o_lv, o_ld);
    else pass_cnt++;
    exp_ld = 32'h1357_9BDF;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    req_valid = 1'b1; ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b1;
    ctrl_word_size = 3'b010; addr = 32'h300;
    @(negedge clk);
    // REQ: async reset must drop mem_req without a clock edge
    #1 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk_cnt++;
    if (mem_req !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL rst_in_req req=%b stall=%b exp 0/0", mem_req, lsu_stall);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    // WAIT
    #2 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk_cnt++;
    if (mem_req !== 1'b0 || lsu_stall !== 1'b0 || load_data !== 32'h0)
      $display("FAIL rst_in_wait req=%b stall=%b ld=%h exp 0/0/00000000", mem_req, lsu_stall, load_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_cnt++;
    if (load_valid !== 1'b0 || load_data !== 32'h0 || lsu_stall !== 1'b0)
      $display("FAIL stray_rvalid lv=%b ld=%h stall=%b exp 0/00000000/0", load_valid, load_data, lsu_stall);
    else pass_cnt++;
    exp_ld = '0;
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a, sd, rdv;
    int          g, rd, wc;
    for (int k = 0; k < 60; k++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 3'($urandom_range(0, 7));
      a   = $urandom;
      sd  = $urandom;
      rdv = $urandom;
      g   = $urandom_range(0, 3);
      rd  = $urandom_range(0, 5);
      run_op(we, sz, a, sd, g, rd, rdv);
      if (!ref_legal(we, sz, a)) begin
        chk_cnt++;
        if (o_mis !== 1'b1 || o_req0 !== 1'b0 || o_stall0 !== 1'b0)
          $display("FAIL rnd%0d_mis we=%b sz=%b a=%h mis=%b req=%b stall=%b exp 1/0/0",
                   k, we, sz, a, o_mis, o_req0, o_stall0);
        else pass_cnt++;
      end else begin
        wc = (rd < TO) ? rd + 1 : TO;
        chk_cnt++;
        if (o_mis !== 1'b0 || o_we !== we || o_be !== ref_be(we, sz, a) ||
            o_addr !== {a[31:2], 2'b00} || (we && o_wdata !== ref_wdata(sz, sd)))
          $display("FAIL rnd%0d_bus we=%b sz=%b a=%h mis=%b be=%b/%b addr=%h wd=%h/%h",
                   k, we, sz, a, o_mis, o_be, ref_be(we, sz, a), o_addr, o_wdata, ref_wdata(sz, sd));
        else pass_cnt++;
        if (rd >= TO) exp_ld = '0;
        else if (!we) exp_ld = ref_load(sz, a, rdv);
        chk_cnt++;
        if (o_nstall !== 2 + g + wc || o_lv !== (!we && rd < TO) ||
            o_berr !== (rd >= TO) || o_ld !== exp_ld)
          $display("FAIL rnd%0d_done sz=%b a=%h ncyc=%0d/%0d lv=%b berr=%b ld=%h exp ld=%h",
                   k, sz, a, o_nstall, 2 + g + wc, o_lv, o_berr, o_ld, exp_ld);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_byte_loads();
    test_stores();
    test_misaligned();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
